// File: rtl/var_bw_mul_pkg.sv
// Shared constants for the variable-bit-width sequential multiplier:
// datapath widths, iteration counts and FSM state encoding.
package var_bw_mul_pkg;

  localparam int OPW       = 16;
  localparam int LANEW     = 8;
  localparam int PW        = 32;
  localparam int ITER_FULL = 16;
  localparam int ITER_PARA = 8;
  localparam int CNTW      = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of shift-add steps for the selected operating mode.
  function automatic logic [CNTW-1:0] iter_count(input logic para);
    return para ? CNTW'(ITER_PARA) : CNTW'(ITER_FULL);
  endfunction

endpackage

// File: rtl/var_bw_add.sv
// 16-bit adder that can split into two independent 8-bit lanes; in split
// mode the high lane takes ci_hi instead of the low lane's carry-out.
module var_bw_add
  import var_bw_mul_pkg::*;
(
  input  logic [OPW-1:0] x,
  input  logic [OPW-1:0] y,
  input  logic           ci_lo,
  input  logic           ci_hi,
  input  logic           para_mode,
  output logic [OPW-1:0] sum,
  output logic           co_lo,
  output logic           co_hi
);

  logic [LANEW:0] lo_sum;
  logic [LANEW:0] hi_sum;
  logic           hi_cin;

  assign lo_sum = {1'b0, x[LANEW-1:0]} + {1'b0, y[LANEW-1:0]} + {{LANEW{1'b0}}, ci_lo};
  assign hi_cin = para_mode ? ci_hi : lo_sum[LANEW];
  assign hi_sum = {1'b0, x[OPW-1:LANEW]} + {1'b0, y[OPW-1:LANEW]} + {{LANEW{1'b0}}, hi_cin};

  assign sum   = {hi_sum[LANEW-1:0], lo_sum[LANEW-1:0]};
  assign co_lo = lo_sum[LANEW];
  assign co_hi = hi_sum[LANEW];

endmodule

// File: rtl/var_bw_mul_seq.sv
// Sequential shift-add multiplier: one 16x16 product in 16 steps, or two
// independent 8x8 lane products in 8 steps, with valid/ready handshakes.
module var_bw_mul_seq
  import var_bw_mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          para_mode,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p
);

  state_t          state_reg;
  logic [CNTW-1:0] cnt_reg;
  logic            mode_reg;
  logic [OPW-1:0]  mcand_reg;
  logic [OPW-1:0]  acc_reg;
  logic [OPW-1:0]  mul_reg;

  logic [OPW-1:0]  acc_next;
  logic [OPW-1:0]  mul_next;
  logic [OPW-1:0]  addend;
  logic [OPW-1:0]  sum;
  logic            co_lo;
  logic            co_hi;
  logic            sel_lo;
  logic            sel_hi;

  // In full mode both halves of the addend follow the single multiplier LSB.
  assign sel_lo = mul_reg[0];
  assign sel_hi = mode_reg ? mul_reg[LANEW] : mul_reg[0];
  assign addend = {sel_hi ? mcand_reg[OPW-1:LANEW] : {LANEW{1'b0}},
                   sel_lo ? mcand_reg[LANEW-1:0]   : {LANEW{1'b0}}};

  var_bw_add u_add (
    .x         (acc_reg),
    .y         (addend),
    .ci_lo     (1'b0),
    .ci_hi     (1'b0),
    .para_mode (mode_reg),
    .sum       (sum),
    .co_lo     (co_lo),
    .co_hi     (co_hi)
  );

  // Each lane shifts {carry, sum, multiplier} right by one; the lanes only
  // stay separate when the latched mode is para.
  always_comb begin
    acc_next = {co_hi, sum[OPW-1:1]};
    mul_next = {sum[0], mul_reg[OPW-1:1]};
    if (mode_reg) begin
      acc_next = {co_hi, sum[OPW-1:LANEW+1], co_lo, sum[LANEW-1:1]};
      mul_next = {sum[LANEW], mul_reg[OPW-1:LANEW+1], sum[0], mul_reg[LANEW-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      mul_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_reg <= a;
            mul_reg   <= b;
            acc_reg   <= '0;
            mode_reg  <= para_mode;
            cnt_reg   <= iter_count(para_mode);
            state_reg <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_reg <= acc_next;
          mul_reg <= mul_next;
          cnt_reg <= cnt_reg - CNTW'(1);
          if (cnt_reg == CNTW'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);

  // Para lane products sit as {acc, mul} per lane; regroup them into p halves.
  assign p = mode_reg ? {acc_reg[OPW-1:LANEW], mul_reg[OPW-1:LANEW],
                         acc_reg[LANEW-1:0],   mul_reg[LANEW-1:0]}
                      : {acc_reg, mul_reg};

endmodule

// File: tb/tb_var_bw_mul_seq.sv
// Scoreboard bench for var_bw_mul_seq: directed corner cases plus random
// full/para operations with random output backpressure.
module tb_var_bw_mul_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        para_mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;

  typedef struct {
    logic [31:0] prod;
    int          due;
    int          hold;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   force_low = 0;
  bit   rand_bp   = 0;

  var_bw_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .para_mode (para_mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic para);
    int unsigned hi, lo;
    if (!para) return 32'(int'(x) * int'(y));
    hi = int'(x[15:8]) * int'(y[15:8]);
    lo = int'(x[7:0]) * int'(y[7:0]);
    return {hi[15:0], lo[15:0]};
  endfunction

  task automatic abort_run(input string what);
    checks++;
    failures++;
    $display("FAIL timeout %s: actual=expired required=completion", what);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tm,
                       input bit push, input int hold_cycles);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      guard++;
      if (guard > 300) abort_run("in_ready");
      @(negedge clk);
    end
    if (hold_cycles > 0) force_low = hold_cycles;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    para_mode = tm;
    if (push) begin
      e.prod = ref_mul(ta, tb, tm);
      e.due  = cyc + 1 + (tm ? 8 : 16);
      e.hold = rand_bp ? -1 : hold_cycles + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = 16'($urandom);
    b         = 16'($urandom);
    para_mode = 1'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0) begin
      guard++;
      if (guard > 500) abort_run("drain");
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Backpressure driver: forced-low window or random/always ready.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (force_low > 0) begin
        out_ready = 1'b0;
        if (out_valid) force_low--;
      end else begin
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: latency, hold-stable, product and post-handshake checks.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_p     = '0;
  bit          hs_prev    = 0;
  int          valid_cnt  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      hs_prev    = 0;
    end else begin
      if (hs_prev) check_val("in_ready_after_hs", 32'(in_ready), 32'd1);
      hs_prev = 0;
      if (prev_valid && !prev_ready) begin
        check_val("hold_valid", 32'(out_valid), 32'd1);
        check_val("hold_p", p, prev_p);
      end
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: actual=1 required=0");
        end else begin
          check_val("latency", 32'(cyc), 32'(sb[0].due));
        end
        valid_cnt = 0;
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check_val("product", p, e.prod);
        if (e.hold >= 0) check_val("valid_cycles", 32'(valid_cnt), 32'(e.hold));
        hs_prev = 1;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_p     = p;
    end
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rm;
    rst       = 1'b1;
    in_valid  = 1'b0;
    para_mode = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_in_ready", 32'(in_ready), 32'd1);
    check_val("reset_out_valid", 32'(out_valid), 32'd0);
    check_val("reset_p", p, 32'd0);
    rst = 1'b0;

    // Directed corner cases, always-ready output except where forced low.
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1, 0);
    do_op(16'hFF03, 16'hFF05, 1'b1, 1, 0);
    do_op(16'h1234, 16'h0000, 1'b0, 1, 5);
    do_op(16'h00FF, 16'h0101, 1'b0, 1, 0);
    do_op(16'h00FF, 16'h0101, 1'b1, 1, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 2);
    drain();

    // Abort a full operation mid-way, then a clean para operation.
    do_op(16'hBEEF, 16'h1234, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_out_valid", 32'(out_valid), 32'd0);
    check_val("abort_in_ready", 32'(in_ready), 32'd1);
    check_val("abort_p", p, 32'd0);
    rst = 1'b0;
    do_op(16'h0202, 16'h0303, 1'b1, 1, 0);
    drain();

    // Random operations with random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 16'hFFFF;
        1:       rb = 16'h0000;
        default: rb = 16'($urandom);
      endcase
      rm = 1'($urandom);
      do_op(ra, rb, rm, 1, 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
